// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one uart_tx byte port among NUM_REQ requesters.
// An owner holds the grant until it sends a last byte, reaches MAX_PKT_LEN bytes, or stalls for TIMEOUT_CYCLES.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_PKT_LEN    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_busy,
    output logic                   o_timeout
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_PKT_LEN + 1);
    localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [BW-1:0] BYTE_LAST = BW'(MAX_PKT_LEN - 1);
    localparam logic [BW-1:0] BYTE_SAT  = {BW{1'b1}};
    localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT_CYCLES > 0) ? IW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IW-1:0] IDLE_SAT  = {IW{1'b1}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [PW-1:0]        r_ptr, w_ptr_nxt;
    logic [PW-1:0]        r_owner, w_owner_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic [BW-1:0]        r_byte_cnt, w_byte_cnt_nxt;
    logic [IW-1:0]        r_idle_cnt, w_idle_cnt_nxt;

    logic                 w_found;
    logic [PW-1:0]        w_pick;
    logic [PW-1:0]        w_idx;
    logic                 w_own_valid;
    logic                 w_xfer;
    logic                 w_to_hit;
    logic                 w_release;

    // Scan starts just after the previous owner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = PW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_own_valid = i_req_valid[r_owner];
    assign w_xfer      = (r_state == S_XFER) && w_own_valid && i_tx_ready;
    assign w_to_hit    = (TIMEOUT_CYCLES != 0) && (r_state == S_XFER) && !w_xfer
                         && (r_idle_cnt == IDLE_LAST);
    assign w_release   = (w_xfer && (i_req_last[r_owner] || (r_byte_cnt == BYTE_LAST))) || w_to_hit;

    assign o_tx_data   = (r_state == S_XFER) ? i_req_data[8*int'(r_owner) +: 8] : 8'h00;
    assign o_tx_valid  = (r_state == S_XFER) && w_own_valid;
    assign o_req_ready = ((r_state == S_XFER) && i_tx_ready) ? r_grant : '0;
    assign o_grant     = r_grant;
    assign o_busy      = r_busy;
    assign o_timeout   = r_timeout;

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_owner_nxt    = r_owner;
        w_grant_nxt    = r_grant;
        w_busy_nxt     = r_busy;
        w_timeout_nxt  = 1'b0;
        w_byte_cnt_nxt = r_byte_cnt;
        w_idle_cnt_nxt = r_idle_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_XFER;
                    w_owner_nxt    = w_pick;
                    w_grant_nxt    = NUM_REQ'(1) << w_pick;
                    w_busy_nxt     = 1'b1;
                    w_byte_cnt_nxt = '0;
                    w_idle_cnt_nxt = '0;
                end
            end
            S_XFER: begin
                if (w_xfer) begin
                    if (r_byte_cnt != BYTE_SAT) w_byte_cnt_nxt = r_byte_cnt + BW'(1);
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt != IDLE_SAT) begin
                    w_idle_cnt_nxt = r_idle_cnt + IW'(1);
                end
                if (w_release) begin
                    w_state_nxt   = S_IDLE;
                    w_ptr_nxt     = r_owner;
                    w_grant_nxt   = '0;
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = w_to_hit;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= PW'(NUM_REQ - 1);
            r_owner    <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_byte_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_grant    <= w_grant_nxt;
            r_busy     <= w_busy_nxt;
            r_timeout  <= w_timeout_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
        end
    end

endmodule
